// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame demultiplexer: FSM state encoding,
// default frame-format parameters and a small elaboration-time helper.
package serial_frame_pkg;

   localparam int                   HDR_W_DEF   = 4;
   localparam logic [HDR_W_DEF-1:0] HDR_PAT_DEF = 4'b0111;
   localparam int                   CH_W_DEF    = 2;
   localparam int                   LEN_W_DEF   = 3;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      CHAN    = 2'd1,
      LEN     = 2'd2,
      PAYLOAD = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/serial_frame_demux_hdr_detector.sv
// Header detector: shift register of the most recent serial bits plus a
// combinational compare against the header pattern, including the bit
// currently on ser_in. clr wipes the history so a new hunt starts from zero.
module hdr_detector
   import serial_frame_pkg::*;
#(
   parameter int               HDR_W   = HDR_W_DEF,
   parameter logic [HDR_W-1:0] HDR_PAT = HDR_PAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic ser_in,
   output logic match
);

   logic [HDR_W-1:0] hdr_sr;
   logic [HDR_W-1:0] window;

   // Window as it will look after this edge: oldest bit dropped, ser_in appended
   assign window = (hdr_sr << 1) | HDR_W'(ser_in);
   assign match  = (window == HDR_PAT);

   // History register, cleared while the framer is busy with field bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_sr <= '0;
      end else if (clr) begin
         hdr_sr <= '0;
      end else begin
         hdr_sr <= window;
      end
   end

endmodule

// File: rtl/serial_frame_demux.sv
// Serial frame demultiplexer: hunts for a header, reads a channel field and a
// length field MSB-first, then steers the payload bits onto the selected
// channel with zero latency. frame_done pulses for one cycle after each frame.
module serial_frame_demux
   import serial_frame_pkg::*;
#(
   parameter int               HDR_W   = HDR_W_DEF,
   parameter logic [HDR_W-1:0] HDR_PAT = HDR_PAT_DEF,
   parameter int               CH_W    = CH_W_DEF,
   parameter int               LEN_W   = LEN_W_DEF,
   localparam int              NCH     = 2**CH_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ser_in,
   output logic [NCH-1:0]  ser_out,
   output logic [NCH-1:0]  ch_valid,
   output logic [CH_W-1:0] frame_ch,
   output logic            busy,
   output logic            frame_done,
   output logic [1:0]      state
);

   // One counter serves both fields, so it is sized for the wider one
   localparam int               CNT_W    = max_int(CH_W, LEN_W);
   localparam logic [CNT_W-1:0] CH_LAST  = CNT_W'(CH_W - 1);
   localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(LEN_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d, len_shift;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              done_q, done_d;
   logic              hdr_clr;
   logic              hdr_match;

   // Header history only accumulates while hunting; any other state wipes it,
   // which also guarantees a zeroed register on re-entry to HUNT.
   assign hdr_clr = (state_q != HUNT);

   hdr_detector #(
      .HDR_W   (HDR_W),
      .HDR_PAT (HDR_PAT)
   ) u_hdr (
      .clk    (clk),
      .rst    (rst),
      .clr    (hdr_clr),
      .ser_in (ser_in),
      .match  (hdr_match)
   );

   // Length value including the bit currently on ser_in
   assign len_shift = (len_q << 1) | LEN_W'(ser_in);

   // Next-state logic: field capture, length countdown and frame-end pulse
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ch_d    = ch_q;
      done_d  = 1'b0;
      case (state_q)
         HUNT: begin
            cnt_d = '0;
            if (hdr_match) begin
               state_d = CHAN;
            end
         end
         CHAN: begin
            ch_d = (ch_q << 1) | CH_W'(ser_in);
            if (cnt_q == CH_LAST) begin
               cnt_d   = '0;
               state_d = LEN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LEN: begin
            len_d = len_shift;
            if (cnt_q == LEN_LAST) begin
               cnt_d = '0;
               if (len_shift == '0) begin
                  state_d = HUNT;
                  done_d  = 1'b1;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PAYLOAD: begin
            len_d = len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
               state_d = HUNT;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // State, counters, captured channel and frame-end pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         len_q   <= '0;
         ch_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ch_q    <= ch_d;
         done_q  <= done_d;
      end
   end

   // Outputs decode straight from the state register, so an asynchronous
   // reset clears valid, data and busy without waiting for a clock edge.
   assign busy       = (state_q != HUNT);
   assign ch_valid   = (state_q == PAYLOAD) ? (NCH'(1) << ch_q) : '0;
   assign ser_out    = ch_valid & {NCH{ser_in}};
   assign frame_ch   = ch_q;
   assign frame_done = done_q;
   assign state      = state_q;

endmodule

// File: tb/tb_serial_frame_demux.sv
// Testbench for serial_frame_demux: a reference parser turns each driven bit
// stream into expected payload/frame-end events; a monitor compares them
// against the DUT outputs as they appear.
module tb_serial_frame_demux;

   localparam int               HDR_W  = 4;
   localparam int               CH_W   = 2;
   localparam int               LEN_W  = 3;
   localparam int               NCH    = 4;
   localparam logic [HDR_W-1:0] TB_PAT = 4'b0111;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            ser_in = 1'b0;
   logic [NCH-1:0]  ser_out;
   logic [NCH-1:0]  ch_valid;
   logic [CH_W-1:0] frame_ch;
   logic            busy;
   logic            frame_done;
   logic [1:0]      state;

   always #5 clk = ~clk;

   serial_frame_demux dut (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (ser_in),
      .ser_out    (ser_out),
      .ch_valid   (ch_valid),
      .frame_ch   (frame_ch),
      .busy       (busy),
      .frame_done (frame_done),
      .state      (state)
   );

   typedef struct {
      bit is_done;
      int ch;
      bit b;
      int idx;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cur_idx = -1;
   bit  mon_en = 1'b0;
   int  st_log[$];
   int  bz_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t, bit idx %0d)", name, act, req, $time, cur_idx);
      end
   endtask

   // Reference parser: hunt with a zero-filled window, read channel and
   // length MSB-first, emit one event per payload bit and one for frame end.
   function automatic void model(input bit bits[$]);
      int n, p, j, pos, ch, len, idx;
      logic [HDR_W-1:0] pat;
      bit v, ok;
      ev_t e;
      pat = TB_PAT;
      n = bits.size();
      p = 0;
      while (p < n) begin
         j = -1;
         for (int k = p; k < n && j < 0; k++) begin
            ok = 1'b1;
            for (int t = 0; t < HDR_W; t++) begin
               idx = k - (HDR_W - 1) + t;
               v = (idx < p) ? 1'b0 : bits[idx];
               if (v != pat[HDR_W-1-t]) ok = 1'b0;
            end
            if (ok) j = k;
         end
         if (j < 0) break;
         pos = j + 1;
         if (pos + CH_W + LEN_W > n) break;
         ch = 0;
         for (int c = 0; c < CH_W; c++) begin
            ch = ch * 2 + int'(bits[pos]);
            pos++;
         end
         len = 0;
         for (int c = 0; c < LEN_W; c++) begin
            len = len * 2 + int'(bits[pos]);
            pos++;
         end
         for (int q = 0; q < len; q++) begin
            if (pos < n) begin
               e.is_done = 1'b0; e.ch = ch; e.b = bits[pos]; e.idx = pos;
               exp_q.push_back(e);
            end
            pos++;
         end
         if (pos < n) begin
            e.is_done = 1'b1; e.ch = ch; e.b = 1'b0; e.idx = pos;
            exp_q.push_back(e);
         end
         p = pos;
      end
   endfunction

   // Monitor: structural checks every cycle, scoreboard pop on any output event
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         chk("lane_gating", 32'(ser_out & ~ch_valid), 32'd0);
         chk("valid_onehot", 32'($countones(ch_valid) > 1), 32'd0);
         if (ch_valid != '0 || frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'({ch_valid, frame_done}), 32'd0);
            end else begin
               mon_ev = exp_q.pop_front();
               if (mon_ev.is_done) begin
                  chk("done_cycle", 32'(cur_idx), 32'(mon_ev.idx));
                  chk("done_pulse", 32'(frame_done), 32'd1);
                  chk("done_ch", 32'(frame_ch), 32'(mon_ev.ch));
               end else begin
                  chk("payload_cycle", 32'(cur_idx), 32'(mon_ev.idx));
                  chk("payload_valid", 32'(ch_valid), 32'(1) << mon_ev.ch);
                  chk("payload_bit", 32'(ser_out), 32'(mon_ev.b) << mon_ev.ch);
               end
            end
         end
      end
   end

   task automatic do_reset(input int cyc);
      rst = 1'b0;
      #1;
      chk("rst_async_ch_valid", 32'(ch_valid), 32'd0);
      chk("rst_async_ser_out", 32'(ser_out), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      ser_in = 1'b0;
      repeat (cyc) @(negedge clk);
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_ch", 32'(frame_ch), 32'd0);
      chk("rst_ch_valid", 32'(ch_valid), 32'd0);
      rst = 1'b1;
   endtask

   task automatic run_stream(input bit bits_in[$]);
      bit bits[$];
      bits = bits_in;
      repeat (16) bits.push_back(1'b0);
      exp_q.delete();
      model(bits);
      st_log.delete();
      bz_log.delete();
      mon_en = 1'b1;
      foreach (bits[i]) begin
         @(negedge clk);
         ser_in  = bits[i];
         cur_idx = i;
         #2;
         st_log.push_back(int'(state));
         bz_log.push_back(int'(busy));
      end
      #1;
      chk("events_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mon_en  = 1'b0;
      cur_idx = -1;
   endtask

   initial begin
      bit s[$];
      bit mr[$];

      // Reset and idle line
      @(negedge clk);
      do_reset(3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ser_in = 1'b0;
         #2;
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Basic frame on channel 2, length 3
      s = '{0, 0,1,1,1, 1,0, 0,1,1, 1,0,1};
      run_stream(s);
      chk("basic_hunt_at_hdr4", 32'(st_log[4]), 32'd0);
      chk("basic_chan_after_hdr", 32'(st_log[5]), 32'd1);
      chk("basic_frame_ch_held", 32'(frame_ch), 32'd2);

      // Zero-length frame
      do_reset(2);
      s = '{0,1,1,1, 0,1, 0,0,0};
      run_stream(s);
      chk("zero_len_busy_in_len", 32'(bz_log[8]), 32'd1);
      chk("zero_len_idle_at_done", 32'(bz_log[9]), 32'd0);
      chk("zero_len_idle_after", 32'(bz_log[10]), 32'd0);

      // Header-like bits inside a payload
      do_reset(2);
      s = '{0,1,1,1, 1,1, 1,1,1, 0,1,1,1,0,1,1};
      run_stream(s);
      chk("false_hdr_hunt_at_done", 32'(st_log[16]), 32'd0);
      chk("false_hdr_idle_after", 32'(bz_log[20]), 32'd0);

      // Back-to-back frames, second header overlapping the frame_done cycle
      do_reset(2);
      s = '{0,1,1,1, 1,1, 0,1,0, 1,0, 0,1,1,1, 0,0, 0,0,1, 1};
      run_stream(s);
      chk("b2b_hunt_at_done", 32'(st_log[11]), 32'd0);
      chk("b2b_second_chan", 32'(st_log[15]), 32'd1);

      // Reset during the second payload bit, then a fresh frame on channel 1
      do_reset(2);
      mr = '{0,1,1,1, 0,0, 1,1,1};
      foreach (mr[i]) begin
         @(negedge clk);
         ser_in = mr[i];
      end
      @(negedge clk);
      ser_in = 1'b1;
      #2;
      chk("mid_rst_pl0_valid", 32'(ch_valid), 32'd1);
      @(negedge clk);
      ser_in = 1'b1;
      #2;
      chk("mid_rst_pl1_data", 32'(ser_out), 32'd1);
      do_reset(3);
      s = '{0,1,1,1, 0,1, 0,0,1, 1};
      run_stream(s);
      chk("mid_rst_next_ch", 32'(frame_ch), 32'd1);

      // Randomized streams with frequent header insertions
      for (int seg = 0; seg < 5; seg++) begin
         s.delete();
         while (s.size() < 160) begin
            if ($urandom_range(0, 3) == 0) begin
               s.push_back(1'b0); s.push_back(1'b1); s.push_back(1'b1); s.push_back(1'b1);
            end else begin
               s.push_back(1'($urandom_range(0, 1)));
            end
         end
         do_reset(2);
         run_stream(s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_frame_demux.md
SERIAL_FRAME_DEMUX -- requirements
Module: serial_frame_demux

Interface
REQ-001 SHALL have parameter HDR_W, default 4, header pattern length in bits.
REQ-002 SHALL have parameter HDR_PAT, default 4'b0111, header pattern (HDR_W bits, MSB received first).
REQ-003 SHALL have parameter CH_W, default 2, channel-field width; NCH = 2**CH_W output channels.
REQ-004 SHALL have parameter LEN_W, default 3, length-field width; payload length 0..2**LEN_W-1 bits.
REQ-005 SHALL have port clk  input  1  single clock, rising-edge active for all state.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ser_in  input  1  serial frame stream, one bit per clk.
REQ-008 SHALL have port ser_out  output  NCH  per-channel serial payload; bit k = ser_in when ch_valid[k], else 0.
REQ-009 SHALL have port ch_valid  output  NCH  one-hot payload-valid, at most one bit set.
REQ-010 SHALL have port frame_ch  output  CH_W  channel of current/most recent frame.
REQ-011 SHALL have port busy  output  1  high in any state other than HUNT.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-013 SHALL have port state  output  2  encoded FSM state for debug.

Function
REQ-014 SHALL implement FSM states HUNT=0, CHAN=1, LEN=2, PAYLOAD=3.
REQ-015 In HUNT, SHALL shift ser_in into an HDR_W-bit register each cycle, and SHALL enter CHAN on the edge where {hdr_sr[HDR_W-2:0], ser_in} == HDR_PAT.
REQ-016 In CHAN, SHALL capture CH_W bits MSB-first into frame_ch, then enter LEN after the last bit.
REQ-017 In LEN, SHALL capture LEN_W bits MSB-first into a down-counter.
REQ-018 On the last LEN bit with captured length 0, SHALL return to HUNT and pulse frame_done the following cycle.
REQ-019 On the last LEN bit with nonzero length, SHALL enter PAYLOAD.
REQ-020 In PAYLOAD, ch_valid[frame_ch] SHALL be 1 combinationally and ser_out[frame_ch] SHALL equal ser_in in the same cycle (zero latency).
REQ-021 PAYLOAD SHALL last exactly length cycles; after the final bit the FSM SHALL enter HUNT and frame_done SHALL be 1 for exactly the next cycle.
REQ-022 On entry to HUNT, the header register SHALL be cleared to all-zero, so no header bits are reused from a frame and a fresh full header is required.
REQ-023 Header-like bits inside the CHAN, LEN or PAYLOAD fields SHALL NOT be detected.
REQ-024 A new header SHALL be accepted starting the cycle frame_done is high (back-to-back frames).
REQ-025 A single field bit counter of width max(CH_W, LEN_W) SHALL be cleared on each field transition.
REQ-026 frame_ch SHALL hold its value in HUNT until the next CHAN capture.

Reset
REQ-027 While rst=0, SHALL force state=HUNT, hdr_sr=0, counters=0, frame_ch=0 and frame_done=0.
REQ-028 While rst=0, ser_out, ch_valid and busy SHALL all be 0 immediately, without waiting for a clock edge.
REQ-029 A reset mid-frame SHALL discard the frame with no frame_done pulse, and hunting SHALL resume on the first edge after release.

Structure
REQ-030 State encoding and default parameter values SHALL live in shared package serial_frame_pkg.
REQ-031 Header matching (shift register plus compare) SHALL be sub-module hdr_detector with ports clk, rst, clr, ser_in, match.
REQ-032 No other sub-modules SHALL be used; the FSM, counters and demux SHALL be in serial_frame_demux.

Verification (defaults, ser_in changes mid-low-phase, sampled at rising edge)
REQ-033 Reset: hold rst=0 for 3 cycles -> all outputs 0 and state=0; after release with ser_in=0 for 10 cycles -> busy stays 0.
REQ-034 Basic frame: stream 0,0111,10,011,101 -> state=1 after 4th header bit, then ch_valid=4'b0100 for 3 cycles with ser_out[2]=1,0,1, then frame_done=1 for 1 cycle and frame_ch=2.
REQ-035 Zero length: stream 0111,01,000 -> ch_valid never set, frame_done pulses 1 cycle after the last length bit, busy=0 afterwards.
REQ-036 False header: stream 0111,11,111,0111011 -> 0111 inside the payload is not detected, ser_out[3]=0,1,1,1,0,1,1, single frame_done.
REQ-037 Reset mid-payload: rst=0 on the 2nd payload bit of 0111,00,111 -> ser_out and ch_valid drop to 0 asynchronously, no frame_done, a following 0111,01,001,1 frame is delivered on ch 1.
REQ-038 Back-to-back: 0111,11,010,10 immediately followed by 0111,00,001,1 -> two frame_done pulses, payload on ch 3 then ch 0, and the second header is accepted during the first frame_done cycle.
